dmem_bank: RTL and testbench

Parametrised 64-bit data memory for the RV64I load/store path, in the memory stage between the LSU and the write-back mux. Adds over the plain RAM:
- sized, byte-strobed stores (SB/SH/SW/SD);
- sized, sign- or zero-extended loads;
- a registered read with a valid pulse;
- same-cycle write-to-read forwarding;
- misalignment and range error flags;
- a sequential clear engine instead of a single-cycle array reset.

---
 rtl/dmem_bank.sv | 153 +++++++++++++++
 tb/tb_dmem_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bank.sv
// 64-bit RV64I data memory: byte-strobed sized stores, extended registered loads,
// same-cycle store-to-load forwarding, error flags and a sequential clear engine.
module dmem_bank #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_W       = 32,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [1:0]        wr_size_i,
    input  logic [63:0]       wr_data_i,
    output logic              wr_err_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [1:0]        rd_size_i,
    input  logic              rd_unsigned_i,
    output logic [63:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {S_CLEAR, S_IDLE} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  clr_idx_q;
    logic              busy_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic              wr_err_q;
    logic [63:0]       rd_data_q;
    logic [63:0]       mem_q [DEPTH];

    // In range and naturally aligned for the access size.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        logic in_range;
        logic aligned;
        in_range = (a >> (IDX_W + 3)) == '0;
        case (sz)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~a[0];
            2'd2:    aligned = (a[1:0] == 2'b00);
            default: aligned = (a[2:0] == 3'b000);
        endcase
        return in_range & aligned;
    endfunction

    function automatic logic [7:0] strobe(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] base;
        case (sz)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    logic             wr_aok, wr_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [2:0]       wr_off;
    logic [7:0]       wr_strb;
    logic [63:0]      wr_lane;
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [2:0]       rd_off;
    logic [63:0]      rd_raw, rd_word, rd_shift, rd_ext;

    assign wr_aok  = addr_ok(wr_addr_i, wr_size_i);
    assign wr_ok   = wr_en_i & wr_aok;
    assign wr_idx  = wr_addr_i[IDX_W+2:3];
    assign wr_off  = wr_addr_i[2:0];
    assign wr_strb = strobe(wr_size_i, wr_off);
    assign wr_lane = wr_data_i << {wr_off, 3'b000};

    assign rd_ok   = addr_ok(rd_addr_i, rd_size_i);
    assign rd_idx  = rd_addr_i[IDX_W+2:3];
    assign rd_off  = rd_addr_i[2:0];
    assign rd_raw  = mem_q[rd_idx];

    // Write-first: a load hitting the word being stored sees the merged bytes.
    always_comb begin
        rd_word = rd_raw;
        if (wr_ok && (wr_idx == rd_idx)) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_strb[b]) rd_word[8*b +: 8] = wr_lane[8*b +: 8];
            end
        end
    end

    assign rd_shift = rd_word >> {rd_off, 3'b000};

    always_comb begin
        rd_ext = rd_shift;
        case (rd_size_i)
            2'd0: rd_ext = rd_unsigned_i ? {56'd0, rd_shift[7:0]}
                                         : {{56{rd_shift[7]}}, rd_shift[7:0]};
            2'd1: rd_ext = rd_unsigned_i ? {48'd0, rd_shift[15:0]}
                                         : {{48{rd_shift[15]}}, rd_shift[15:0]};
            2'd2: rd_ext = rd_unsigned_i ? {32'd0, rd_shift[31:0]}
                                         : {{32{rd_shift[31]}}, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Array has no reset; the clear engine zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (rst_n && state_q == S_IDLE && wr_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_lane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_idx_q  <= '0;
            busy_q     <= CLR_ON_RESET;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else if (state_q == S_CLEAR) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            clr_idx_q  <= clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            rd_valid_q <= rd_en_i;
            rd_err_q   <= rd_en_i & ~rd_ok;
            wr_err_q   <= wr_en_i & ~wr_aok;
            if (rd_en_i) rd_data_q <= rd_ok ? rd_ext : '0;
        end
    end

    assign init_busy_o = busy_q;
    assign wr_err_o    = wr_err_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_err_o    = rd_err_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank (DEPTH=16): clear engine, sized loads/stores,
// forwarding, error flags and reset in the middle of a load stream.
module tb_dmem_bank;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_busy_o;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [1:0]        wr_size_i;
    logic [63:0]       wr_data_i;
    logic              wr_err_o;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [1:0]        rd_size_i;
    logic              rd_unsigned_i;
    logic [63:0]       rd_data_o;
    logic              rd_valid_o;
    logic              rd_err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .init_busy_o(init_busy_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_size_i(wr_size_i),
        .wr_data_i(wr_data_i), .wr_err_o(wr_err_o),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_size_i(rd_size_i),
        .rd_unsigned_i(rd_unsigned_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .rd_err_o(rd_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] wa;
        logic [1:0]  ws;
        logic [63:0] wd;
        logic        re;
        logic [31:0] ra;
        logic [1:0]  rs;
        logic        ru;
        logic        ev;
        logic [63:0] ed;
        logic        ee;
        logic        ewe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic we, logic [31:0] wa, logic [1:0] ws,
                                logic [63:0] wd, logic re, logic [31:0] ra, logic [1:0] rs,
                                logic ru, logic ev, logic [63:0] ed, logic ee, logic ewe);
        vec_t v;
        v.nm = nm; v.we = we; v.wa = wa; v.ws = ws; v.wd = wd;
        v.re = re; v.ra = ra; v.rs = rs; v.ru = ru;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ewe = ewe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en_i = 0; wr_addr_i = '0; wr_size_i = 2'd0; wr_data_i = '0;
        rd_en_i = 0; rd_addr_i = '0; rd_size_i = 2'd0; rd_unsigned_i = 0;
    endtask

    // Holds rst_n low for two edges, checks reset values, releases at a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy",  init_busy_o, 1);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_data",  rd_data_o, 0);
        chk("rst_rderr", rd_err_o, 0);
        chk("rst_wrerr", wr_err_o, 0);
        rst_n = 1'b1;
    endtask

    // Counts cycles with init_busy_o high; any rd_valid_o/err during busy is a failure.
    task automatic wait_clear(input string nm);
        int  cnt;
        bit  stray;
        cnt = 0;
        stray = 0;
        for (int i = 0; i < 200; i++) begin
            if (!init_busy_o) break;
            cnt++;
            if (rd_valid_o || rd_err_o || wr_err_o) stray = 1;
            step();
        end
        chk({nm, "_busy_cycles"}, cnt, DEPTH);
        chk({nm, "_no_resp_in_busy"}, stray, 0);
        chk({nm, "_no_valid_at_exit"}, rd_valid_o, 0);
    endtask

    task automatic load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [63:0] exp);
        idle_inputs();
        rd_en_i = 1; rd_addr_i = a; rd_size_i = sz; rd_unsigned_i = u;
        step();
        chk({nm, "_valid"}, rd_valid_o, 1);
        chk({nm, "_data"}, rd_data_o, exp);
        idle_inputs();
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] d);
        idle_inputs();
        wr_en_i = 1; wr_addr_i = a; wr_size_i = sz; wr_data_i = d;
        step();
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);

        // Clear after reset; a load held high during busy must not respond.
        rd_en_i = 1; rd_addr_i = 32'h18; rd_size_i = 2'd3;
        do_reset();
        wait_clear("clr1");
        idle_inputs();

        // Preload a nonzero word, reset, and confirm the clear wiped it.
        store(32'h18, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        load("preload", 32'h18, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_reset();
        wait_clear("clr2");
        load("after_clear", 32'h18, 2'd3, 0, 64'h0);

        //             name        we wa     ws wd                     re ra     rs ru  ev ed                     ee ewe
        vecs.push_back(mk("sd10",     1, 32'h10, 3, 64'h8877665544332211, 0, 32'h0,  0, 0, 0, 64'h0,                0, 0));
        vecs.push_back(mk("lb17",     0, 32'h0,  0, 64'h0,                1, 32'h17, 0, 0, 1, 64'hFFFFFFFFFFFFFF88, 0, 0));
        vecs.push_back(mk("lbu17",    0, 32'h0,  0, 64'h0,                1, 32'h17, 0, 1, 1, 64'h0000000000000088, 0, 0));
        vecs.push_back(mk("lh16",     0, 32'h0,  0, 64'h0,                1, 32'h16, 1, 0, 1, 64'hFFFFFFFFFFFF8877, 0, 0));
        vecs.push_back(mk("lwu14",    0, 32'h0,  0, 64'h0,                1, 32'h14, 2, 1, 1, 64'h0000000088776655, 0, 0));
        vecs.push_back(mk("sb13",     1, 32'h13, 0, 64'h123456789ABCDEAA, 0, 32'h0,  0, 0, 0, 64'h0000000088776655, 0, 0));
        vecs.push_back(mk("ld10",     0, 32'h0,  0, 64'h0,                1, 32'h10, 3, 0, 1, 64'h88776655AA332211, 0, 0));
        vecs.push_back(mk("sw22_mis", 1, 32'h22, 2, 64'hDEADBEEF,         0, 32'h0,  0, 0, 0, 64'h88776655AA332211, 0, 1));
        vecs.push_back(mk("ld20",     0, 32'h0,  0, 64'h0,                1, 32'h20, 3, 0, 1, 64'h0,                0, 0));
        vecs.push_back(mk("lh11_mis", 0, 32'h0,  0, 64'h0,                1, 32'h11, 1, 0, 1, 64'h0,                1, 0));
        vecs.push_back(mk("ld80_oor", 0, 32'h0,  0, 64'h0,                1, 32'h80, 3, 0, 1, 64'h0,                1, 0));
        vecs.push_back(mk("ld10b",    0, 32'h0,  0, 64'h0,                1, 32'h10, 3, 0, 1, 64'h88776655AA332211, 0, 0));
        vecs.push_back(mk("hold",     0, 32'h0,  0, 64'h0,                0, 32'h0,  0, 0, 0, 64'h88776655AA332211, 0, 0));
        vecs.push_back(mk("fwd_sh08", 1, 32'h08, 1, 64'hBEEF,             1, 32'h08, 3, 0, 1, 64'h000000000000BEEF, 0, 0));
        vecs.push_back(mk("othr_wd",  1, 32'h0A, 1, 64'h1234,             1, 32'h10, 3, 0, 1, 64'h88776655AA332211, 0, 0));
        vecs.push_back(mk("ld08",     0, 32'h0,  0, 64'h0,                1, 32'h08, 3, 0, 1, 64'h000000001234BEEF, 0, 0));
        vecs.push_back(mk("nofwd_er", 1, 32'h0A, 2, 64'hFFFFFFFF,         1, 32'h08, 3, 0, 1, 64'h000000001234BEEF, 0, 1));
        vecs.push_back(mk("fwd_sw0c", 1, 32'h0C, 2, 64'hCAFEF00D,         1, 32'h0C, 2, 0, 1, 64'hFFFFFFFFCAFEF00D, 0, 0));
        vecs.push_back(mk("lhu0e",    0, 32'h0,  0, 64'h0,                1, 32'h0E, 1, 1, 1, 64'h000000000000CAFE, 0, 0));
        vecs.push_back(mk("lb0c",     0, 32'h0,  0, 64'h0,                1, 32'h0C, 0, 0, 1, 64'h000000000000000D, 0, 0));
        vecs.push_back(mk("ld08_u",   0, 32'h0,  0, 64'h0,                1, 32'h08, 3, 1, 1, 64'hCAFEF00D1234BEEF, 0, 0));
        vecs.push_back(mk("sd04_mis", 1, 32'h04, 3, 64'h1,                1, 32'h04, 2, 1, 1, 64'h0,                0, 1));
        vecs.push_back(mk("sd78",     1, 32'h78, 3, 64'h0123456789ABCDEF, 0, 32'h0,  0, 0, 0, 64'h0,                0, 0));
        vecs.push_back(mk("lw7c",     0, 32'h0,  0, 64'h0,                1, 32'h7C, 2, 0, 1, 64'h0000000001234567, 0, 0));
        vecs.push_back(mk("lh7e",     0, 32'h0,  0, 64'h0,                1, 32'h7E, 1, 0, 1, 64'h0000000000000123, 0, 0));
        vecs.push_back(mk("sd80_oor", 1, 32'h80, 3, 64'hFFFFFFFFFFFFFFFF, 1, 32'h00, 3, 0, 1, 64'h0,                0, 1));
        vecs.push_back(mk("ld00",     0, 32'h0,  0, 64'h0,                1, 32'h00, 3, 0, 1, 64'h0,                0, 0));

        foreach (vecs[i]) begin
            wr_en_i = vecs[i].we; wr_addr_i = vecs[i].wa; wr_size_i = vecs[i].ws;
            wr_data_i = vecs[i].wd; rd_en_i = vecs[i].re; rd_addr_i = vecs[i].ra;
            rd_size_i = vecs[i].rs; rd_unsigned_i = vecs[i].ru;
            step();
            chk({vecs[i].nm, "_valid"}, rd_valid_o, vecs[i].ev);
            chk({vecs[i].nm, "_data"},  rd_data_o,  vecs[i].ed);
            chk({vecs[i].nm, "_rderr"}, rd_err_o,   vecs[i].ee);
            chk({vecs[i].nm, "_wrerr"}, wr_err_o,   vecs[i].ewe);
        end
        idle_inputs();
        step();
        chk("wrerr_pulse_end", wr_err_o, 0);

        // Back-to-back loads, then a one-cycle reset in the middle of the stream.
        rd_en_i = 1; rd_addr_i = 32'h78; rd_size_i = 2'd3; rd_unsigned_i = 0;
        step();
        chk("stream1_valid", rd_valid_o, 1);
        chk("stream1_data", rd_data_o, 64'h0123456789ABCDEF);
        rd_addr_i = 32'h10;
        step();
        chk("stream2_valid", rd_valid_o, 1);
        chk("stream2_data", rd_data_o, 64'h88776655AA332211);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", rd_valid_o, 0);
        chk("midrst_data", rd_data_o, 64'h0);
        chk("midrst_busy", init_busy_o, 1);
        rst_n = 1'b1;
        wait_clear("clr3");
        idle_inputs();
        load("post_rst_78", 32'h78, 2'd3, 0, 64'h0);
        load("post_rst_10", 32'h10, 2'd3, 0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
